pxy_bridge: RTL and testbench
=============================

PXY_BRIDGE -- requirements
Module: pxy_bridge

Interface
REQ-001 Parameter NUM_CH, default 4, sets the number of proxy peripheral channels (1..16).
REQ-002 Parameter TIMEOUT, default 15, sets the maximum wait cycles for a peripheral acknowledge (1..255).
REQ-003 CORE_CLK  in  1  is the single core clock; all state updates on its rising edge.
REQ-004 RST_n  in  1  is the reset: asynchronous assert, active-low.
REQ-005 SFR_WR  in  1  is the one-cycle SFR write strobe from the BIU.
REQ-006 SFR_ADDR  in  8  is the SFR address; the block decodes 0xC0-0xC3 only.
REQ-007 SFR_DIN  in  8  is the SFR write data.
REQ-008 SFR_DOUT  out  8  is the SFR read data for the address on SFR_ADDR (combinational).
REQ-009 PER_ADDR  out  4  is the registered peripheral sub-address, taken from the proxy address bits [3:0].
REQ-010 PER_DOUT  out  8  is the registered peripheral write data.
REQ-011 PER_WR  out  NUM_CH  is the one-hot write request, one bit per channel.
REQ-012 PER_RD  out  NUM_CH  is the one-hot read request, one bit per channel.
REQ-013 PER_DIN  in  8*NUM_CH  is the per-channel read data; channel n occupies bits [8n+7:8n].
REQ-014 PER_ACK  in  NUM_CH  is the per-channel transfer acknowledge.
REQ-015 BUSY  out  1  is high while a proxy transfer is outstanding.

Function
REQ-016 SFR map:
- 0xC0 read = captured read data.
- 0xC1 write = write data, and starts a write.
- 0xC2 write = address, and starts a read.
- 0xC3 = status. Bit0 BUSY, bit1 ERR (timeout/bad channel), bit2 OVR (start while busy), bit3 RDV (read data valid). Writing 1 to bit1/bit2 clears that bit. Bits [7:4] read 0.
- Any other address reads 8'hEE.
REQ-017 The state machine has three states: IDLE, WR, RD. BUSY = (state != IDLE).
REQ-018 Write to 0xC1 in IDLE at cycle n: latch PER_DOUT, enter WR at n+1, drive PER_WR[ch] high from n+1.
REQ-019 Write to 0xC2 in IDLE at cycle n: latch address, clear RDV, enter RD at n+1, drive PER_RD[ch] high from n+1.
REQ-020 Channel select: ch = proxy address[7:4]. For writes, the channel comes from the address latched by the last 0xC2 write.
REQ-021 A request bit stays high until the cycle PER_ACK[ch] is sampled high; the state returns to IDLE at the next edge.
REQ-022 Read acknowledge at cycle k: PER_DIN channel ch is captured at k+1, and RDV is set at k+1.
REQ-023 Zero-wait peripheral (ACK tied high): a transfer occupies exactly one cycle in WR/RD, and BUSY is high for exactly one cycle.
REQ-024 Wait counter: 8-bit, cleared on entry to WR/RD, incremented each cycle without ACK.
REQ-025 Timeout: when the counter equals TIMEOUT without ACK, the transfer aborts.
- Request is deasserted.
- ERR is set.
- For reads, captured data = 8'hEE and RDV is set.
- State returns to IDLE.
REQ-026 If ACK and the timeout condition occur in the same cycle, the ACK wins: normal completion, ERR unchanged.
REQ-027 Bad channel (ch >= NUM_CH): no request is asserted; the transfer completes one cycle after start with ERR set and, for reads, data 8'hEE.
REQ-028 A write to 0xC1/0xC2 while BUSY is ignored: no latch update and no new transfer; OVR is set.
REQ-029 PER_ACK bits of unselected channels, or any ACK in IDLE, are ignored.
REQ-030 At most one PER_WR/PER_RD bit is high in any cycle, and never both PER_WR and PER_RD.
REQ-031 A 0xC3 clear-write and a same-cycle ERR/OVR set event resolve to set.

Reset
REQ-032 RST_n low immediately forces the following, independent of CORE_CLK:
- state IDLE, BUSY 0.
- PER_WR/PER_RD all 0.
- PER_ADDR 0, PER_DOUT 0.
- captured data 0.
- ERR/OVR/RDV 0, wait counter 0.
REQ-033 Reset asserted mid-transfer aborts it with no ERR. After release, the first edge with RST_n high accepts a new start.

Verification
REQ-034 Write 0xC2=0x13, ACK[1] high on the first request cycle, PER_DIN ch1=0x5A -> PER_RD=0010 for 1 cycle; 0xC0 reads 0x5A; 0xC3 reads 0x08.
REQ-035 Write 0xC1=0xA7 with address 0x20, ACK[2] after 3 wait cycles -> PER_WR[2] high 4 cycles, PER_DOUT=0xA7, PER_ADDR=0, ERR=0.
REQ-036 Read from channel 3 with ACK never asserted, TIMEOUT=15 -> request drops after 16 cycles in RD; 0xC0=0xEE; 0xC3=0x0A.
REQ-037 Write 0xC2=0x70 (NUM_CH=4) -> no PER_RD bit rises, BUSY high 1 cycle, ERR=1, 0xC0=0xEE; writing 0xC3=0x02 clears ERR.
REQ-038 Write 0xC1 during a pending read -> PER_DOUT unchanged, OVR=1, the read completes normally.
REQ-039 Assert RST_n low mid-WR, between clock edges -> PER_WR drops without an edge; all outputs at reset values.

Source files
------------

// File: rtl/pxy_bridge_if.sv
// rtl/pxy_bridge_if.sv - SFR-side and peripheral-side signal bundle for the proxy bridge
interface pxy_bridge_if #(
  parameter int NUM_CH = 4
);
  logic                  SFR_WR;
  logic [7:0]            SFR_ADDR;
  logic [7:0]            SFR_DIN;
  logic [7:0]            SFR_DOUT;
  logic [3:0]            PER_ADDR;
  logic [7:0]            PER_DOUT;
  logic [NUM_CH-1:0]     PER_WR;
  logic [NUM_CH-1:0]     PER_RD;
  logic [8*NUM_CH-1:0]   PER_DIN;
  logic [NUM_CH-1:0]     PER_ACK;
  logic                  BUSY;

  modport slave (
    input  SFR_WR, SFR_ADDR, SFR_DIN, PER_DIN, PER_ACK,
    output SFR_DOUT, PER_ADDR, PER_DOUT, PER_WR, PER_RD, BUSY
  );

  modport master (
    output SFR_WR, SFR_ADDR, SFR_DIN, PER_DIN, PER_ACK,
    input  SFR_DOUT, PER_ADDR, PER_DOUT, PER_WR, PER_RD, BUSY
  );
endinterface

// File: rtl/pxy_bridge.sv
// rtl/pxy_bridge.sv - SFR-mapped proxy bridge issuing one read/write at a time to NUM_CH peripherals
module pxy_bridge #(
  parameter int NUM_CH  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic           CORE_CLK,
  input  logic           RST_n,
  pxy_bridge_if.slave    bus
);
  localparam logic [4:0] NCH = 5'(NUM_CH);
  localparam logic [7:0] TMO = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [7:0]        addr_q;
  logic [7:0]        dout_q;
  logic [7:0]        rdata_q;
  logic [7:0]        wait_cnt;
  logic              err_q;
  logic              ovr_q;
  logic              rdv_q;

  logic              wr_c1;
  logic              wr_c2;
  logic              wr_c3;
  logic [3:0]        ch;
  logic              ch_ok;
  logic              busy;
  logic              ack_sel;
  logic [7:0]        din_sel;
  logic [NUM_CH-1:0] req_vec;

  logic              start_wr;
  logic              start_rd;
  logic              done_ok;
  logic              done_abort;
  logic              cnt_inc;

  assign wr_c1 = bus.SFR_WR && (bus.SFR_ADDR == 8'hC1);
  assign wr_c2 = bus.SFR_WR && (bus.SFR_ADDR == 8'hC2);
  assign wr_c3 = bus.SFR_WR && (bus.SFR_ADDR == 8'hC3);

  // Writes reuse the channel of the last accepted address write
  assign ch    = addr_q[7:4];
  assign ch_ok = ({1'b0, ch} < NCH);
  assign busy  = (state != IDLE);

  always_comb begin
    ack_sel = 1'b0;
    din_sel = 8'h00;
    req_vec = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch == 4'(i)) begin
        ack_sel    = bus.PER_ACK[i];
        din_sel    = bus.PER_DIN[i*8 +: 8];
        req_vec[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge CORE_CLK or negedge RST_n) begin
    if (!RST_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    start_wr   = 1'b0;
    start_rd   = 1'b0;
    done_ok    = 1'b0;
    done_abort = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (wr_c1) begin
          start_wr = 1'b1;
          state_nx = WR;
        end else if (wr_c2) begin
          start_rd = 1'b1;
          state_nx = RD;
        end
      end
      WR, RD: begin
        // An ACK on the timeout cycle still counts as a normal completion
        if (!ch_ok) begin
          done_abort = 1'b1;
          state_nx   = IDLE;
        end else if (ack_sel) begin
          done_ok  = 1'b1;
          state_nx = IDLE;
        end else if (wait_cnt == TMO) begin
          done_abort = 1'b1;
          state_nx   = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CORE_CLK or negedge RST_n) begin
    if (!RST_n) begin
      addr_q   <= 8'h00;
      dout_q   <= 8'h00;
      rdata_q  <= 8'h00;
      wait_cnt <= 8'h00;
      err_q    <= 1'b0;
      ovr_q    <= 1'b0;
      rdv_q    <= 1'b0;
    end else begin
      if (start_wr) begin
        dout_q <= bus.SFR_DIN;
      end
      if (start_rd) begin
        addr_q <= bus.SFR_DIN;
      end

      if (start_wr || start_rd) begin
        wait_cnt <= 8'h00;
      end else if (cnt_inc) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      if (state == RD && done_ok) begin
        rdata_q <= din_sel;
      end else if (state == RD && done_abort) begin
        rdata_q <= 8'hEE;
      end

      if (start_rd) begin
        rdv_q <= 1'b0;
      end else if (state == RD && (done_ok || done_abort)) begin
        rdv_q <= 1'b1;
      end

      // Set events take priority over a same-cycle write-one-to-clear
      if (done_abort) begin
        err_q <= 1'b1;
      end else if (wr_c3 && bus.SFR_DIN[1]) begin
        err_q <= 1'b0;
      end

      if (busy && (wr_c1 || wr_c2)) begin
        ovr_q <= 1'b1;
      end else if (wr_c3 && bus.SFR_DIN[2]) begin
        ovr_q <= 1'b0;
      end
    end
  end

  always_comb begin
    case (bus.SFR_ADDR)
      8'hC0:   bus.SFR_DOUT = rdata_q;
      8'hC1:   bus.SFR_DOUT = dout_q;
      8'hC2:   bus.SFR_DOUT = addr_q;
      8'hC3:   bus.SFR_DOUT = {4'b0000, rdv_q, ovr_q, err_q, busy};
      default: bus.SFR_DOUT = 8'hEE;
    endcase
  end

  assign bus.PER_WR   = (state == WR) ? req_vec : '0;
  assign bus.PER_RD   = (state == RD) ? req_vec : '0;
  assign bus.PER_ADDR = addr_q[3:0];
  assign bus.PER_DOUT = dout_q;
  assign bus.BUSY     = busy;
endmodule

// File: tb/tb_pxy_bridge.sv
// tb/tb_pxy_bridge.sv - self-checking bench for pxy_bridge (vector table, corner sequences, random vs model)
module tb_pxy_bridge;
  localparam int NUM_CH = 4;
  localparam int TMO    = 15;

  logic CORE_CLK;
  logic RST_n;

  pxy_bridge_if #(.NUM_CH(NUM_CH)) bus ();

  pxy_bridge #(.NUM_CH(NUM_CH), .TIMEOUT(TMO)) dut (
    .CORE_CLK (CORE_CLK),
    .RST_n    (RST_n),
    .bus      (bus)
  );

  initial CORE_CLK = 1'b0;
  always #5 CORE_CLK = ~CORE_CLK;

  int errors = 0;
  int checks = 0;

  logic [7:0] din_arr [NUM_CH];
  logic [7:0] m_addr, m_dout, m_rdata;
  logic       m_err, m_ovr, m_rdv;

  typedef struct {
    bit         is_wr;
    logic [7:0] val;
    int         delay;
    logic [7:0] din;
    int         exp_req;
    int         exp_busy;
    logic [7:0] exp_rdata;
    logic [7:0] exp_stat;
    logic [7:0] exp_dout;
    logic [3:0] exp_paddr;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic sfr_write(input logic [7:0] a, input logic [7:0] d);
    bus.SFR_WR   = 1'b1;
    bus.SFR_ADDR = a;
    bus.SFR_DIN  = d;
    @(posedge CORE_CLK); #1;
    bus.SFR_WR   = 1'b0;
  endtask

  task automatic sfr_read(input logic [7:0] a, output logic [7:0] d);
    bus.SFR_ADDR = a;
    #1;
    d = bus.SFR_DOUT;
  endtask

  task automatic drive_din();
    for (int i = 0; i < NUM_CH; i++) bus.PER_DIN[i*8 +: 8] = din_arr[i];
  endtask

  function automatic logic [7:0] m_status();
    return {4'b0000, m_rdv, m_ovr, m_err, 1'b0};
  endfunction

  task automatic model_reset();
    m_addr = 8'h00; m_dout = 8'h00; m_rdata = 8'h00;
    m_err = 1'b0; m_ovr = 1'b0; m_rdv = 1'b0;
  endtask

  // Outcome of one transfer from the SFR-level rules: channel, ack delay, timeout
  task automatic model_xfer(input bit is_wr, input logic [7:0] val, input int delay, input bit poke,
                            output int ereq, output int ebusy);
    int ch;
    bit good;
    if (poke) m_ovr = 1'b1;
    if (is_wr) m_dout = val;
    else begin
      m_addr = val;
      m_rdv  = 1'b0;
    end
    ch   = int'(m_addr[7:4]);
    good = (ch < NUM_CH);
    if (!good) begin
      ereq = 0; ebusy = 1; m_err = 1'b1;
      if (!is_wr) begin m_rdata = 8'hEE; m_rdv = 1'b1; end
    end else if (delay >= 0 && delay <= TMO) begin
      ereq = delay + 1; ebusy = delay + 1;
      if (!is_wr) begin m_rdata = din_arr[ch]; m_rdv = 1'b1; end
    end else begin
      ereq = TMO + 1; ebusy = TMO + 1; m_err = 1'b1;
      if (!is_wr) begin m_rdata = 8'hEE; m_rdv = 1'b1; end
    end
  endtask

  task automatic do_xfer(input bit is_wr, input logic [7:0] val, input int delay, input bit poke,
                         output int req_n, output int busy_n, output bit viol);
    int ch;
    int w;
    logic [NUM_CH-1:0] sel, rq, other, noise;
    ch  = is_wr ? int'(m_addr[7:4]) : int'(val[7:4]);
    sel = '0;
    if (ch < NUM_CH) sel[ch] = 1'b1;
    drive_din();
    bus.SFR_WR   = 1'b1;
    bus.SFR_ADDR = is_wr ? 8'hC1 : 8'hC2;
    bus.SFR_DIN  = val;
    bus.PER_ACK  = NUM_CH'($urandom);
    @(posedge CORE_CLK); #1;
    bus.SFR_WR = 1'b0;
    req_n = 0; busy_n = 0; viol = 1'b0; w = 0;
    while (bus.BUSY && w < 40) begin
      busy_n++;
      rq    = is_wr ? bus.PER_WR : bus.PER_RD;
      other = is_wr ? bus.PER_RD : bus.PER_WR;
      if ((rq & sel) != '0) req_n++;
      if (other != '0 || (rq & ~sel) != '0) viol = 1'b1;
      noise = NUM_CH'($urandom);
      bus.PER_ACK = noise & ~sel;
      if (w == delay) bus.PER_ACK = bus.PER_ACK | sel;
      if (poke && w == 0) begin
        bus.SFR_WR   = 1'b1;
        bus.SFR_ADDR = $urandom_range(0, 1) ? 8'hC1 : 8'hC2;
        bus.SFR_DIN  = 8'($urandom);
      end
      @(posedge CORE_CLK); #1;
      bus.SFR_WR = 1'b0;
      w++;
    end
    bus.PER_ACK = '0;
    if ((bus.PER_WR | bus.PER_RD) != '0) viol = 1'b1;
    chk("busy_bound", {31'd0, bus.BUSY}, 32'd0);
  endtask

  task automatic post_check(input string tag, input int req_n, input int busy_n, input bit viol,
                            input int ereq, input int ebusy, input logic [7:0] erd,
                            input logic [7:0] est, input logic [7:0] edout, input logic [3:0] epa);
    logic [7:0] d;
    chk({tag, "_req_cycles"}, req_n, ereq);
    chk({tag, "_busy_cycles"}, busy_n, ebusy);
    chk({tag, "_onehot"}, {31'd0, viol}, 32'd0);
    sfr_read(8'hC0, d);
    chk({tag, "_rdata"}, {24'd0, d}, {24'd0, erd});
    sfr_read(8'hC3, d);
    chk({tag, "_status"}, {24'd0, d}, {24'd0, est});
    chk({tag, "_per_dout"}, {24'd0, bus.PER_DOUT}, {24'd0, edout});
    chk({tag, "_per_addr"}, {28'd0, bus.PER_ADDR}, {28'd0, epa});
  endtask

  initial begin
    logic [7:0] d;
    int req_n, busy_n, ereq, ebusy, ch, delay, r;
    bit viol, is_wr, poke;
    logic [7:0] val, v;

    tbl[0] = '{1'b0, 8'h13,  0, 8'h5A,  1,  1, 8'h5A, 8'h08, 8'h00, 4'h3};
    tbl[1] = '{1'b0, 8'h20,  0, 8'h11,  1,  1, 8'h11, 8'h08, 8'h00, 4'h0};
    tbl[2] = '{1'b1, 8'hA7,  3, 8'h00,  4,  4, 8'h11, 8'h08, 8'hA7, 4'h0};
    tbl[3] = '{1'b0, 8'h35, -1, 8'h00, 16, 16, 8'hEE, 8'h0A, 8'hA7, 4'h5};
    tbl[4] = '{1'b0, 8'h31, 15, 8'h3C, 16, 16, 8'h3C, 8'h08, 8'hA7, 4'h1};
    tbl[5] = '{1'b1, 8'h5C, 16, 8'h00, 16, 16, 8'h3C, 8'h0A, 8'h5C, 4'h1};
    tbl[6] = '{1'b0, 8'h70,  0, 8'h00,  0,  1, 8'hEE, 8'h0A, 8'h5C, 4'h0};
    tbl[7] = '{1'b1, 8'h99,  0, 8'h00,  0,  1, 8'hEE, 8'h0A, 8'h99, 4'h0};

    RST_n = 1'b0;
    bus.SFR_WR = 1'b0; bus.SFR_ADDR = 8'h00; bus.SFR_DIN = 8'h00;
    bus.PER_ACK = '0; bus.PER_DIN = '0;
    for (int i = 0; i < NUM_CH; i++) din_arr[i] = 8'h00;
    model_reset();
    #12;
    chk("rst_busy", {31'd0, bus.BUSY}, 32'd0);
    chk("rst_per_wr", {28'd0, bus.PER_WR}, 32'd0);
    chk("rst_per_rd", {28'd0, bus.PER_RD}, 32'd0);
    chk("rst_per_dout", {24'd0, bus.PER_DOUT}, 32'd0);
    chk("rst_per_addr", {28'd0, bus.PER_ADDR}, 32'd0);
    sfr_read(8'hC0, d); chk("rst_rdata", {24'd0, d}, 32'd0);
    sfr_read(8'hC3, d); chk("rst_status", {24'd0, d}, 32'd0);
    sfr_read(8'h55, d); chk("unmapped_read", {24'd0, d}, 32'h0000_00EE);
    RST_n = 1'b1;
    @(posedge CORE_CLK); #1;

    for (int i = 0; i < 8; i++) begin
      sfr_write(8'hC3, 8'h06);
      m_err = 1'b0; m_ovr = 1'b0;
      ch = tbl[i].is_wr ? int'(m_addr[7:4]) : int'(tbl[i].val[7:4]);
      if (ch < NUM_CH) din_arr[ch] = tbl[i].din;
      do_xfer(tbl[i].is_wr, tbl[i].val, tbl[i].delay, 1'b0, req_n, busy_n, viol);
      model_xfer(tbl[i].is_wr, tbl[i].val, tbl[i].delay, 1'b0, ereq, ebusy);
      post_check($sformatf("vec%0d", i), req_n, busy_n, viol, tbl[i].exp_req, tbl[i].exp_busy,
                 tbl[i].exp_rdata, tbl[i].exp_stat, tbl[i].exp_dout, tbl[i].exp_paddr);
    end

    sfr_write(8'hC3, 8'h02);
    m_err = 1'b0;
    sfr_read(8'hC3, d); chk("err_clear", {24'd0, d}, 32'h0000_0008);

    // ERR set by a bad-channel abort in the same cycle as a clear write
    sfr_write(8'hC3, 8'h06);
    m_err = 1'b0; m_ovr = 1'b0;
    sfr_write(8'hC2, 8'h70);
    sfr_write(8'hC3, 8'h02);
    m_addr = 8'h70; m_err = 1'b1; m_rdv = 1'b1; m_rdata = 8'hEE;
    sfr_read(8'hC3, d); chk("set_beats_clear", {24'd0, d}, 32'h0000_000A);
    sfr_read(8'hC0, d); chk("bad_ch_rdata", {24'd0, d}, 32'h0000_00EE);

    // Write start while a read is pending
    sfr_write(8'hC3, 8'h06);
    m_err = 1'b0; m_ovr = 1'b0;
    din_arr[1] = 8'h6D;
    drive_din();
    sfr_write(8'hC2, 8'h12);
    sfr_write(8'hC1, 8'h44);
    chk("ovr_per_dout", {24'd0, bus.PER_DOUT}, {24'd0, m_dout});
    chk("ovr_per_rd", {28'd0, bus.PER_RD}, 32'h0000_0002);
    sfr_read(8'hC3, d); chk("ovr_status_busy", {24'd0, d}, 32'h0000_0005);
    bus.PER_ACK = 4'b0010;
    @(posedge CORE_CLK); #1;
    bus.PER_ACK = '0;
    m_addr = 8'h12; m_rdata = 8'h6D; m_rdv = 1'b1; m_ovr = 1'b1;
    chk("ovr_done_busy", {31'd0, bus.BUSY}, 32'd0);
    sfr_read(8'hC0, d); chk("ovr_rdata", {24'd0, d}, 32'h0000_006D);
    sfr_read(8'hC3, d); chk("ovr_status_done", {24'd0, d}, 32'h0000_000C);

    // Asynchronous reset in the middle of a write
    do_xfer(1'b0, 8'h21, 0, 1'b0, req_n, busy_n, viol);
    model_xfer(1'b0, 8'h21, 0, 1'b0, ereq, ebusy);
    post_check("pre_rst", req_n, busy_n, viol, ereq, ebusy, m_rdata, m_status(), m_dout, m_addr[3:0]);
    sfr_write(8'hC1, 8'h3C);
    chk("mid_wr_req", {28'd0, bus.PER_WR}, 32'h0000_0004);
    #3;
    RST_n = 1'b0;
    #1;
    chk("arst_per_wr", {28'd0, bus.PER_WR}, 32'd0);
    chk("arst_busy", {31'd0, bus.BUSY}, 32'd0);
    chk("arst_per_dout", {24'd0, bus.PER_DOUT}, 32'd0);
    chk("arst_per_addr", {28'd0, bus.PER_ADDR}, 32'd0);
    sfr_read(8'hC0, d); chk("arst_rdata", {24'd0, d}, 32'd0);
    sfr_read(8'hC3, d); chk("arst_status", {24'd0, d}, 32'd0);
    RST_n = 1'b1;
    model_reset();
    do_xfer(1'b0, 8'h23, 1, 1'b0, req_n, busy_n, viol);
    model_xfer(1'b0, 8'h23, 1, 1'b0, ereq, ebusy);
    post_check("post_rst", req_n, busy_n, viol, ereq, ebusy, m_rdata, m_status(), m_dout, m_addr[3:0]);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        v = 8'($urandom);
        sfr_write(8'hC3, v);
        if (v[1]) m_err = 1'b0;
        if (v[2]) m_ovr = 1'b0;
      end
      for (int i = 0; i < NUM_CH; i++) din_arr[i] = 8'($urandom);
      is_wr = ($urandom_range(0, 1) == 1);
      val   = 8'($urandom);
      if ($urandom_range(0, 3) != 0) val[7:4] = 4'($urandom_range(0, NUM_CH - 1));
      r = $urandom_range(0, 9);
      delay = (r == 0) ? -1 : (r == 1) ? TMO : (r == 2) ? TMO + 1 : $urandom_range(0, 5);
      poke  = ($urandom_range(0, 4) == 0);
      do_xfer(is_wr, val, delay, poke, req_n, busy_n, viol);
      model_xfer(is_wr, val, delay, poke, ereq, ebusy);
      post_check($sformatf("rnd%0d", k), req_n, busy_n, viol, ereq, ebusy,
                 m_rdata, m_status(), m_dout, m_addr[3:0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
